// File: rtl/sd_spi_init_seq_pkg.sv
// sd_init_pkg: states, command bytes, R1 codes and error causes for the SD SPI bring-up sequencer
package sd_init_pkg;
    typedef enum logic [3:0] {
        IDLE, DUMMY, WDUMMY, CMD0, W0, CMD8, W8, CMD55, W55,
        A41, W41, CMD58, W58, SPEEDUP, DONE, ERR
    } state_t;
    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_CMD0    = 3'd1,
        ERR_CMD8    = 3'd2,
        ERR_R1      = 3'd3,
        ERR_ACMD41  = 3'd4,
        ERR_CMD58   = 3'd5,
        ERR_TIMEOUT = 3'd6
    } err_t;
    localparam logic [7:0]  CMD0_BYTE      = 8'h40;
    localparam logic [7:0]  CMD8_BYTE      = 8'h48;
    localparam logic [7:0]  CMD55_BYTE     = 8'h77;
    localparam logic [7:0]  ACMD41_BYTE    = 8'h69;
    localparam logic [7:0]  CMD58_BYTE     = 8'h7A;
    localparam logic [7:0]  R1_IDLE        = 8'h01;
    localparam logic [7:0]  R1_READY       = 8'h00;
    localparam int          R1_ILLEGAL_BIT = 2;
    localparam logic [11:0] CMD8_CHECK     = 12'h1AA;
    localparam logic [31:0] CMD8_ARG       = 32'h0000_01AA;
    localparam logic [31:0] ACMD41_HCS     = 32'h4000_0000;
endpackage

// File: rtl/sd_spi_init_seq_watchdog.sv
// sd_watchdog: response timeout counter with clear, enable and expired flag
module sd_watchdog #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_limit,
    input  logic         i_clr,
    input  logic         i_en,
    output logic         o_expired
);
    logic [W-1:0] r_cnt;
    // The clearing (issue) cycle counts as the first elapsed cycle.
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else if (i_clr) r_cnt <= W'(1);
        else if (i_en) r_cnt <= r_cnt + W'(1);
    end
    assign o_expired = i_en && (r_cnt + W'(1) == i_limit);
endmodule

// File: rtl/sd_spi_init_seq.sv
// sd_spi_init_seq: hardware SD card SPI-mode init sequencer driving the SPI core's pulse controls
module sd_spi_init_seq
    import sd_init_pkg::*;
#(
    parameter logic [15:0] CMD0_RETRIES   = 16'd8,
    parameter logic [15:0] ACMD41_RETRIES = 16'd1000,
    parameter logic [23:0] RESP_TIMEOUT   = 24'd1_000_000,
    parameter logic [1:0]  SPEED_INIT     = 2'd1,
    parameter logic [1:0]  SPEED_FAST     = 2'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    output logic        o_init_c,
    input  logic        i_init_done,
    output logic        o_com_start,
    output logic [7:0]  o_com_cmd,
    output logic [31:0] o_com_arg,
    input  logic        i_com_done,
    input  logic [7:0]  i_com_r1,
    input  logic [31:0] i_com_r7,
    output logic [1:0]  o_speed,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [2:0]  o_err_code,
    output logic        o_card_v2,
    output logic        o_card_hc
);
    state_t      r_state, w_next;
    err_t        r_err_code, w_code;
    logic [15:0] r_retry;
    logic [1:0]  r_speed;
    logic        r_busy, r_done, r_err, r_card_v2, r_card_hc;
    logic        w_issue, w_wait, w_expired, w_retry_clr, w_retry_inc, w_v2_set, w_hc_ld;
    logic        w_unused;

    assign w_issue = r_state inside {DUMMY, CMD0, CMD8, CMD55, A41, CMD58};
    assign w_wait  = r_state inside {WDUMMY, W0, W8, W55, W41, W58};
    assign w_unused = ^{i_com_r7[31], i_com_r7[29:12]};

    sd_watchdog #(.W(24)) u_wd (
        .clk(clk), .rst(rst), .i_limit(RESP_TIMEOUT),
        .i_clr(w_issue), .i_en(w_wait), .o_expired(w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_code      = ERR_NONE;
        w_retry_clr = 1'b0;
        w_retry_inc = 1'b0;
        w_v2_set    = 1'b0;
        w_hc_ld     = 1'b0;
        case (r_state)
            IDLE:    w_next = i_start ? DUMMY : IDLE;
            DUMMY:   w_next = WDUMMY;
            WDUMMY:  w_next = i_init_done ? CMD0 : WDUMMY;
            CMD0:    w_next = W0;
            W0: if (i_com_done) begin
                if (i_com_r1 == R1_IDLE) begin
                    w_next      = CMD8;
                    w_retry_clr = 1'b1;
                end else if (r_retry + 16'd1 == CMD0_RETRIES) begin
                    w_next = ERR;
                    w_code = ERR_CMD0;
                end else begin
                    w_next      = CMD0;
                    w_retry_inc = 1'b1;
                end
            end
            CMD8:    w_next = W8;
            W8: if (i_com_done) begin
                if (i_com_r1 == R1_IDLE && i_com_r7[11:0] == CMD8_CHECK) begin
                    w_next   = CMD55;
                    w_v2_set = 1'b1;
                end else if (i_com_r1[R1_ILLEGAL_BIT]) begin
                    w_next = CMD55;
                end else begin
                    w_next = ERR;
                    w_code = ERR_CMD8;
                end
            end
            CMD55:   w_next = W55;
            W55: if (i_com_done) begin
                w_next = (i_com_r1 == R1_READY || i_com_r1 == R1_IDLE) ? A41 : ERR;
                w_code = (i_com_r1 == R1_READY || i_com_r1 == R1_IDLE) ? ERR_NONE : ERR_R1;
            end
            A41:     w_next = W41;
            W41: if (i_com_done) begin
                if (i_com_r1 == R1_READY) begin
                    w_next = r_card_v2 ? CMD58 : SPEEDUP;
                end else if (i_com_r1 == R1_IDLE) begin
                    w_next      = (r_retry + 16'd1 == ACMD41_RETRIES) ? ERR : CMD55;
                    w_code      = (r_retry + 16'd1 == ACMD41_RETRIES) ? ERR_ACMD41 : ERR_NONE;
                    w_retry_inc = 1'b1;
                end else begin
                    w_next = ERR;
                    w_code = ERR_R1;
                end
            end
            CMD58:   w_next = W58;
            W58: if (i_com_done) begin
                w_next  = (i_com_r1 == R1_READY) ? SPEEDUP : ERR;
                w_code  = (i_com_r1 == R1_READY) ? ERR_NONE : ERR_CMD58;
                w_hc_ld = (i_com_r1 == R1_READY);
            end
            SPEEDUP: w_next = DONE;
            default: w_next = IDLE;
        endcase
        // A completion arriving in the expiry cycle still wins over the timeout.
        if (w_expired && w_next == r_state) begin
            w_next = ERR;
            w_code = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retry    <= '0;
            r_speed    <= SPEED_INIT;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_card_v2  <= 1'b0;
            r_card_hc  <= 1'b0;
        end else begin
            if (r_state == IDLE && i_start) begin
                r_retry    <= '0;
                r_speed    <= SPEED_INIT;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
                r_err      <= 1'b0;
                r_err_code <= ERR_NONE;
                r_card_v2  <= 1'b0;
                r_card_hc  <= 1'b0;
            end
            if (w_retry_clr) r_retry <= '0;
            else if (w_retry_inc) r_retry <= r_retry + 16'd1;
            if (w_v2_set) r_card_v2 <= 1'b1;
            if (w_hc_ld) r_card_hc <= i_com_r7[30];
            if (r_state == SPEEDUP) r_speed <= SPEED_FAST;
            if (w_next == DONE) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
            if (w_next == ERR) begin
                r_err      <= 1'b1;
                r_busy     <= 1'b0;
                r_err_code <= w_code;
            end
        end
    end

    assign o_init_c    = (r_state == DUMMY);
    assign o_com_start = w_issue && (r_state != DUMMY);
    assign o_com_cmd   = (r_state == CMD0)  ? CMD0_BYTE   :
                         (r_state == CMD8)  ? CMD8_BYTE   :
                         (r_state == CMD55) ? CMD55_BYTE  :
                         (r_state == A41)   ? ACMD41_BYTE :
                         (r_state == CMD58) ? CMD58_BYTE  : 8'h00;
    assign o_com_arg   = (r_state == CMD8) ? CMD8_ARG :
                         (r_state == A41 && r_card_v2) ? ACMD41_HCS : 32'h0;
    assign o_speed     = r_speed;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_err_code  = r_err_code;
    assign o_card_v2   = r_card_v2;
    assign o_card_hc   = r_card_hc;
endmodule

// File: tb/tb_sd_spi_init_seq.sv
// tb_sd_spi_init_seq: directed and randomized card scenarios checked against a command-level model
module tb_sd_spi_init_seq;
    logic        clk = 1'b0, rst = 1'b1, i_start = 1'b0;
    logic        o_init_c, i_init_done, o_com_start, i_com_done;
    logic [7:0]  o_com_cmd, i_com_r1;
    logic [31:0] o_com_arg, i_com_r7;
    logic [1:0]  o_speed;
    logic        o_busy, o_done, o_err, o_card_v2, o_card_hc;
    logic [2:0]  o_err_code;

    sd_spi_init_seq #(.ACMD41_RETRIES(16'd4), .RESP_TIMEOUT(24'd100)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .o_init_c(o_init_c), .i_init_done(i_init_done),
        .o_com_start(o_com_start), .o_com_cmd(o_com_cmd), .o_com_arg(o_com_arg),
        .i_com_done(i_com_done), .i_com_r1(i_com_r1), .i_com_r7(i_com_r7), .o_speed(o_speed),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_err_code(o_err_code),
        .o_card_v2(o_card_v2), .o_card_hc(o_card_hc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // card scenario
    int c0_bad, c8_kind, a41_busy, silent_at;
    bit c55_bad, a41_bad, c58_bad;
    logic [31:0] ocr;
    // card model state
    int n0, na, issue_idx, pend = 0, last_pulse, idle_bad = 0, lat_max = 4;
    bit pend_init;
    logic [7:0]  rsp_r1;
    logic [31:0] rsp_r7;
    logic [7:0]  got_cmds[$];
    logic [31:0] got_args[$];
    // reference expectations
    logic [7:0]  exp_cmds[$];
    logic [31:0] exp_args[$];
    bit e_done, e_err, e_v2, e_hc;
    int e_code, ek;
    int n_pass = 0, n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Card: answers each pulse after 1..lat_max cycles unless it is the silent one.
    initial begin
        logic [31:0] r;
        i_init_done = 1'b0; i_com_done = 1'b0; i_com_r1 = '0; i_com_r7 = '0;
        forever begin
            @(negedge clk);
            i_init_done = 1'b0;
            i_com_done  = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0 && pend_init) i_init_done = 1'b1;
                if (pend == 0 && !pend_init) begin
                    i_com_done = 1'b1;
                    i_com_r1   = rsp_r1;
                    i_com_r7   = rsp_r7;
                end
            end
            if (!o_com_start && (o_com_cmd !== 8'h00 || o_com_arg !== 32'h0)) idle_bad++;
            if (o_init_c) begin
                last_pulse = cyc;
                issue_idx  = 0;
                pend_init  = 1'b1;
                if (silent_at != 0) pend = $urandom_range(1, lat_max);
            end
            if (o_com_start) begin
                last_pulse = cyc;
                issue_idx++;
                got_cmds.push_back(o_com_cmd);
                got_args.push_back(o_com_arg);
                r = $urandom;
                rsp_r7 = r;
                rsp_r1 = 8'hFF;
                case (o_com_cmd)
                    8'h40: begin n0++; rsp_r1 = (n0 <= c0_bad) ? 8'hFF : 8'h01; end
                    8'h48: begin
                        rsp_r1 = (c8_kind == 1) ? 8'h05 : (c8_kind == 2 && r[0]) ? 8'h09 : 8'h01;
                        rsp_r7 = {r[31:12], (c8_kind == 2) ? 12'h1AB : 12'h1AA};
                    end
                    8'h77: rsp_r1 = c55_bad ? 8'h04 : {7'd0, r[1]};
                    8'h69: begin na++; rsp_r1 = (na <= a41_busy) ? 8'h01 : a41_bad ? 8'h02 : 8'h00; end
                    8'h7A: begin rsp_r1 = c58_bad ? 8'h08 : 8'h00; rsp_r7 = ocr; end
                    default: rsp_r1 = 8'hFF;
                endcase
                pend_init = 1'b0;
                if (issue_idx != silent_at) pend = $urandom_range(1, lat_max);
            end
        end
    end

    function automatic bit issue(input logic [7:0] c, input logic [31:0] a);
        exp_cmds.push_back(c);
        exp_args.push_back(a);
        ek++;
        return ek == silent_at;
    endfunction

    // Expected command trace and outcome, derived from the bring-up rules.
    task automatic predict();
        exp_cmds.delete(); exp_args.delete();
        e_done = 0; e_err = 1; e_code = 6; e_v2 = 0; e_hc = 0; ek = 0;
        if (silent_at == 0) return;
        for (int i = 0; i < 8; i++) begin
            if (issue(8'h40, 0)) return;
            if (i >= c0_bad) break;
            if (i == 7) begin e_code = 1; return; end
        end
        if (issue(8'h48, 32'h1AA)) return;
        if (c8_kind == 2) begin e_code = 2; return; end
        e_v2 = (c8_kind == 0);
        for (int i = 0; i < 4; i++) begin
            if (issue(8'h77, 0)) return;
            if (c55_bad) begin e_code = 3; return; end
            if (issue(8'h69, e_v2 ? 32'h4000_0000 : 32'h0)) return;
            if (i >= a41_busy) begin
                if (a41_bad) begin e_code = 3; return; end
                break;
            end
            if (i == 3) begin e_code = 4; return; end
        end
        if (e_v2) begin
            if (issue(8'h7A, 0)) return;
            if (c58_bad) begin e_code = 5; return; end
            e_hc = ocr[30];
        end
        e_done = 1; e_err = 0; e_code = 0;
    endtask

    task automatic scn(input int c0, input int c8, input int ab, input bit b55, input bit b41,
                       input bit b58, input logic [31:0] o, input int sil);
        c0_bad = c0; c8_kind = c8; a41_busy = ab; c55_bad = b55; a41_bad = b41;
        c58_bad = b58; ocr = o; silent_at = sil;
    endtask

    task automatic start_run();
        predict();
        n0 = 0; na = 0;
        got_cmds.delete(); got_args.delete();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic finish_run(input string nm);
        int t = 0;
        int poke = $urandom_range(2, 40);
        chk({nm, ".busy_on"}, o_busy, 1);
        while (!(o_done || o_err) && t < 5000) begin
            i_start = (t == poke);
            @(negedge clk);
            t++;
        end
        i_start = 1'b0;
        chk({nm, ".finished"}, o_done || o_err, 1);
        if (e_code == 6) chk({nm, ".tmo_cycles"}, cyc - last_pulse, 100);
        chk({nm, ".done"}, o_done, e_done);
        chk({nm, ".err"}, o_err, e_err);
        chk({nm, ".err_code"}, o_err_code, e_code);
        chk({nm, ".card_v2"}, o_card_v2, e_v2);
        chk({nm, ".card_hc"}, o_card_hc, e_hc);
        chk({nm, ".speed"}, o_speed, e_done ? 3 : 1);
        chk({nm, ".busy_off"}, o_busy, 0);
        chk({nm, ".ncmds"}, got_cmds.size(), exp_cmds.size());
        for (int i = 0; i < exp_cmds.size() && i < got_cmds.size(); i++) begin
            chk($sformatf("%s.cmd%0d", nm, i), got_cmds[i], exp_cmds[i]);
            chk($sformatf("%s.arg%0d", nm, i), got_args[i], exp_args[i]);
        end
        chk({nm, ".idle_cmd_arg"}, idle_bad, 0);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk({nm, ".start_in_end_ignored"}, o_busy, 0);
        chk({nm, ".level_kept"}, o_done, e_done);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, ".init_c"}, o_init_c, 0);
        chk({nm, ".com_start"}, o_com_start, 0);
        chk({nm, ".com_cmd"}, o_com_cmd, 0);
        chk({nm, ".com_arg"}, o_com_arg, 0);
        chk({nm, ".speed"}, o_speed, 1);
        chk({nm, ".busy"}, o_busy, 0);
        chk({nm, ".done"}, o_done, 0);
        chk({nm, ".err"}, o_err, 0);
        chk({nm, ".err_code"}, o_err_code, 0);
        chk({nm, ".card_v2"}, o_card_v2, 0);
        chk({nm, ".card_hc"}, o_card_hc, 0);
    endtask

    initial begin
        int t;
        scn(0, 0, 0, 0, 0, 0, 0, -1);
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        scn(0, 0, 2, 0, 0, 0, 32'hC0FF_8000, -1);
        start_run(); finish_run("v2hc");
        chk("v2hc.nine_cmds", got_cmds.size(), 9);
        scn(0, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, -1);
        start_run(); finish_run("v1");
        scn(99, 0, 0, 0, 0, 0, 0, -1);
        start_run(); finish_run("cmd0_dead");
        scn(0, 0, 99, 0, 0, 0, 0, -1);
        start_run(); finish_run("a41_stuck");
        scn(0, 0, 0, 0, 0, 0, 0, 2);
        start_run(); finish_run("cmd8_silent");

        // Reset while waiting on ACMD41, then a clean run.
        scn(0, 0, 3, 0, 0, 0, 32'h4000_0000, -1);
        start_run();
        t = 0;
        while (!(o_com_start && o_com_cmd == 8'h69) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("rst41.reached_a41", o_com_cmd, 8'h69);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("rst41");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        scn(1, 0, 1, 0, 0, 0, 32'hC000_0000, -1);
        start_run(); finish_run("after_rst");

        for (int i = 0; i < 40; i++) begin
            scn(($urandom_range(0, 4) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 5),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                $urandom, ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : -1);
            start_run();
            finish_run($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
